nesapu_pulse_ch: RTL and testbench
==================================

NESAPU_PULSE_CH -- requirements
Module: nesapu_pulse_ch

Interface
REQ-001 Parameter ONES_COMP, default 0: sweep negate mode; 1 = ones'-complement (pulse 1), 0 = two's-complement (pulse 2).
REQ-002 Parameter MUTE_MIN, default 8: periods below this value mute the channel.
REQ-003 in_clk  input  1  system clock; single clock domain.
REQ-004 in_rst  input  1  reset; asynchronous, active-high.
REQ-005 in_ce  input  1  APU-cycle strobe; the timer advances only on cycles where in_ce=1.
REQ-006 in_wr  input  1  single-cycle register write strobe.
REQ-007 in_addr  input  2  register select, 0..3.
REQ-008 in_val  input  8  register write data.
REQ-009 in_enable  input  1  channel enable ($4015 bit).
REQ-010 in_quarter  input  1  quarter-frame tick, one cycle wide.
REQ-011 in_half  input  1  half-frame tick, one cycle wide.
REQ-012 out_level  output  4  channel amplitude, 0..15.
REQ-013 out_active  output  1  length counter nonzero.

Function
REQ-014 Reg0 SHALL hold duty[7:6], halt/loop[5], const[4], vol[3:0]; reg1 sweep en[7], P[6:4], negate[3], shift[2:0]; reg2 timer[7:0]; reg3 length index[7:3], timer[10:8].
REQ-015 Writes SHALL take effect on the cycle after in_wr=1.
REQ-016 Timer: 11-bit down-counter; on in_ce with count 0, reload with period and advance sequencer index 0..7 with wrap 7->0; otherwise decrement.
REQ-017 Duty patterns, index 0 first: 0=01000000, 1=01100000, 2=01111000, 3=10011111.
REQ-018 Reg3 write SHALL reset sequencer index to 0, set envelope start flag, and reload length from table entry [7:3] when in_enable=1.
REQ-019 Length table, entries 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-020 Length: on in_half with halt=0 and count>0, decrement; reg3 reload beats a same-cycle decrement; in_enable=0 forces count 0 next cycle.
REQ-021 Envelope, on in_quarter: if start flag set, clear it, decay=15, divider=vol; else divider 0 -> divider=vol and decay-1, or decay=15 if decay=0 and loop=1; else divider-1.
REQ-022 Envelope output SHALL be vol when const=1, else decay.
REQ-023 Reg3 write coincident with in_quarter SHALL set the start flag; the restart happens on the next quarter tick.
REQ-024 Sweep target SHALL be period + (period>>shift), or on negate period - (period>>shift) - ONES_COMP, computed 12 bits wide.
REQ-025 Sweep mute SHALL assert when period < MUTE_MIN or target bit 11 = 1 with negate=0, regardless of sweep en.
REQ-026 On in_half: if divider=0, en=1, shift!=0 and not muted, period <= target[10:0]; then if divider=0 or reload flag, divider <= P and clear reload flag, else divider-1.
REQ-027 Reg1 write SHALL set the sweep reload flag; a reg2/reg3 write coincident with a sweep update SHALL win.
REQ-028 out_level SHALL be 0 when duty bit=0, length=0, sweep mute, or in_enable=0; otherwise envelope output; combinational from registered state, no extra latency.
REQ-029 out_active SHALL equal (length != 0).

Reset
REQ-030 in_rst SHALL asynchronously clear all registers, timer, sequencer index, length, envelope decay/divider/start, and sweep divider/reload flag to 0.
REQ-031 During and immediately after reset, out_level=0 and out_active=0; writes while in_rst=1 SHALL be ignored.

Configuration
REQ-032 Macro NESAPU_SWEEP_EN: defined -> sweep unit and sweep mute per REQ-024..027.
REQ-033 NESAPU_SWEEP_EN undefined -> reg1 writes ignored, period changes only by reg2/reg3 writes, sweep mute never asserts.

Verification
REQ-034 Reg0=0xBF, reg2=0x08, reg3=0x08, in_enable=1, in_ce every cycle -> out_level pattern 0,15,15,15,15,0,0,0 (duty 2), each step 9 in_ce long.
REQ-035 Reg0=0x02 (decay, vol 2), reg3 write, quarter ticks -> decay 15 then drops by 1 every 3 quarter ticks, holds at 0.
REQ-036 Reg3 index 1 (254), halt=0, 254 half ticks -> out_active falls on the 254th; in_enable=0 mid-count -> out_active=0 next cycle.
REQ-037 Period 0x100, reg1=0x81 (P=0, shift 1), ONES_COMP=1, negate set -> one half tick gives period 0x07F; negate clear -> 0x180.
REQ-038 Period 0x7F0, shift 1, negate clear -> out_level=0 (target overflow) with sweep en=0; period 0x007 -> out_level=0.
REQ-039 Assert in_rst mid-note at random cycle -> out_level=0 and out_active=0 within the same cycle, no in_clk edge needed.

Source files
------------

// File: rtl/nesapu_pulse_ch.sv
// rtl/nesapu_pulse_ch.sv - NES APU pulse channel: timer, duty sequencer, envelope, length, sweep.
// Sweep unit and sweep mute are built only when NESAPU_SWEEP_EN is defined.
module nesapu_pulse_ch #(
  parameter int ONES_COMP = 0,
  parameter int MUTE_MIN  = 8
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_ce,
  input  logic       in_wr,
  input  logic [1:0] in_addr,
  input  logic [7:0] in_val,
  input  logic       in_enable,
  input  logic       in_quarter,
  input  logic       in_half,
  output logic [3:0] out_level,
  output logic       out_active
);

  logic [1:0]  duty;
  logic        halt;
  logic        const_vol;
  logic [3:0]  vol;
  logic [10:0] period;
  logic [10:0] timer;
  logic [2:0]  seq_idx;
  logic [7:0]  length;
  logic        env_start;
  logic [3:0]  env_decay;
  logic [3:0]  env_div;
  logic        sweep_mute;
  logic        wr_r2;
  logic        wr_r3;

  assign wr_r2 = in_wr && (in_addr == 2'd2);
  assign wr_r3 = in_wr && (in_addr == 2'd3);

  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;  5'd1:  v = 8'd254; 5'd2:  v = 8'd20;  5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;  5'd5:  v = 8'd4;   5'd6:  v = 8'd80;  5'd7:  v = 8'd6;
      5'd8:  v = 8'd160; 5'd9:  v = 8'd8;   5'd10: v = 8'd60;  5'd11: v = 8'd10;
      5'd12: v = 8'd14;  5'd13: v = 8'd12;  5'd14: v = 8'd26;  5'd15: v = 8'd14;
      5'd16: v = 8'd12;  5'd17: v = 8'd16;  5'd18: v = 8'd24;  5'd19: v = 8'd18;
      5'd20: v = 8'd48;  5'd21: v = 8'd20;  5'd22: v = 8'd96;  5'd23: v = 8'd22;
      5'd24: v = 8'd192; 5'd25: v = 8'd24;  5'd26: v = 8'd72;  5'd27: v = 8'd26;
      5'd28: v = 8'd16;  5'd29: v = 8'd28;  5'd30: v = 8'd32;  default: v = 8'd30;
    endcase
    return v;
  endfunction

  // Bit i of each pattern is sequencer step i.
  function automatic logic duty_bit(input logic [1:0] d, input logic [2:0] i);
    logic [7:0] pat;
    case (d)
      2'd0:    pat = 8'b0000_0010;
      2'd1:    pat = 8'b0000_0110;
      2'd2:    pat = 8'b0001_1110;
      default: pat = 8'b1111_1001;
    endcase
    return pat[i];
  endfunction

`ifdef NESAPU_SWEEP_EN
  logic        sweep_en;
  logic [2:0]  sweep_p;
  logic        sweep_negate;
  logic [2:0]  sweep_shift;
  logic [2:0]  sweep_div;
  logic        sweep_reload;
  logic [11:0] sweep_delta;
  logic [11:0] sweep_target;
  logic        sweep_fire;

  assign sweep_delta  = {1'b0, period >> sweep_shift};
  assign sweep_target = sweep_negate ? ({1'b0, period} - sweep_delta - 12'(ONES_COMP))
                                     : ({1'b0, period} + sweep_delta);
  assign sweep_mute   = (period < 11'(MUTE_MIN)) || (!sweep_negate && sweep_target[11]);
  assign sweep_fire   = in_half && (sweep_div == 3'd0) && sweep_en &&
                        (sweep_shift != 3'd0) && !sweep_mute;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      sweep_div    <= 3'd0;
      sweep_reload <= 1'b0;
    end else begin
      if (in_half) begin
        if (sweep_div == 3'd0 || sweep_reload) begin
          sweep_div    <= sweep_p;
          sweep_reload <= 1'b0;
        end else begin
          sweep_div <= sweep_div - 3'd1;
        end
      end
      if (in_wr && in_addr == 2'd1) sweep_reload <= 1'b1;
    end
  end
`else
  assign sweep_mute = 1'b0;
`endif

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      duty      <= 2'd0;
      halt      <= 1'b0;
      const_vol <= 1'b0;
      vol       <= 4'd0;
`ifdef NESAPU_SWEEP_EN
      sweep_en     <= 1'b0;
      sweep_p      <= 3'd0;
      sweep_negate <= 1'b0;
      sweep_shift  <= 3'd0;
`endif
    end else if (in_wr) begin
      case (in_addr)
        2'd0: {duty, halt, const_vol, vol} <= in_val;
`ifdef NESAPU_SWEEP_EN
        2'd1: {sweep_en, sweep_p, sweep_negate, sweep_shift} <= in_val;
`endif
        default: ;
      endcase
    end
  end

  // CPU writes to the period bytes take priority over a same-cycle sweep update.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) period <= 11'd0;
    else if (wr_r2) period <= {period[10:8], in_val};
    else if (wr_r3) period <= {in_val[2:0], period[7:0]};
`ifdef NESAPU_SWEEP_EN
    else if (sweep_fire) period <= sweep_target[10:0];
`endif
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      timer   <= 11'd0;
      seq_idx <= 3'd0;
    end else begin
      if (in_ce) begin
        if (timer == 11'd0) begin
          timer   <= period;
          seq_idx <= seq_idx + 3'd1;
        end else begin
          timer <= timer - 11'd1;
        end
      end
      if (wr_r3) seq_idx <= 3'd0;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) length <= 8'd0;
    else if (!in_enable) length <= 8'd0;
    else if (wr_r3) length <= len_lut(in_val[7:3]);
    else if (in_half && !halt && length != 8'd0) length <= length - 8'd1;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      env_start <= 1'b0;
      env_decay <= 4'd0;
      env_div   <= 4'd0;
    end else begin
      if (in_quarter) begin
        if (env_start) begin
          env_start <= 1'b0;
          env_decay <= 4'd15;
          env_div   <= vol;
        end else if (env_div == 4'd0) begin
          env_div <= vol;
          if (env_decay != 4'd0) env_decay <= env_decay - 4'd1;
          else if (halt) env_decay <= 4'd15;
        end else begin
          env_div <= env_div - 4'd1;
        end
      end
      // A restart requested alongside a quarter tick is served on the following tick.
      if (wr_r3) env_start <= 1'b1;
    end
  end

  assign out_active = (length != 8'd0);
  assign out_level  = (duty_bit(duty, seq_idx) && out_active && !sweep_mute && in_enable)
                      ? (const_vol ? vol : env_decay) : 4'd0;

endmodule

// File: tb/tb_nesapu_pulse_ch.sv
// tb/tb_nesapu_pulse_ch.sv - self-checking bench for nesapu_pulse_ch against a behavioural model.
module tb_nesapu_pulse_ch;
  localparam int ONES = 1;
  localparam int MMIN = 8;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       in_ce = 1'b0;
  logic       in_wr = 1'b0;
  logic [1:0] in_addr = 2'd0;
  logic [7:0] in_val = 8'd0;
  logic       in_enable = 1'b1;
  logic       in_quarter = 1'b0;
  logic       in_half = 1'b0;
  logic [3:0] out_level;
  logic       out_active;

  always #5 in_clk = ~in_clk;

  nesapu_pulse_ch #(.ONES_COMP(ONES), .MUTE_MIN(MMIN)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_ce(in_ce), .in_wr(in_wr),
    .in_addr(in_addr), .in_val(in_val), .in_enable(in_enable),
    .in_quarter(in_quarter), .in_half(in_half),
    .out_level(out_level), .out_active(out_active)
  );

  int total = 0;
  int bad = 0;

  int len_tab[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                      12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
  string duty_pat[4] = '{"01000000", "01100000", "01111000", "10011111"};

  // Channel state as the programmer sees it.
  int m_duty = 0, m_halt = 0, m_const = 0, m_vol = 0;
  int m_sen = 0, m_sp = 0, m_neg = 0, m_shift = 0;
  int m_period = 0, m_timer = 0, m_step = 0, m_len = 0;
  int m_estart = 0, m_decay = 0, m_ediv = 0, m_sdiv = 0, m_sreload = 0;

  function automatic int tgt(int p, int sh, int ng);
    if (ng != 0) return (p - (p >> sh) - ONES) & 'hFFF;
    return (p + (p >> sh)) & 'hFFF;
  endfunction

  function automatic int model_mute();
`ifdef NESAPU_SWEEP_EN
    if (m_period < MMIN) return 1;
    if (m_neg == 0 && tgt(m_period, m_shift, 0) >= 2048) return 1;
`endif
    return 0;
  endfunction

  function automatic int expected_level();
    if (duty_pat[m_duty].getc(m_step) == "1" && m_len != 0 && model_mute() == 0 && in_enable)
      return (m_const != 0) ? m_vol : m_decay;
    return 0;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_duty = 0; m_halt = 0; m_const = 0; m_vol = 0;
    m_sen = 0; m_sp = 0; m_neg = 0; m_shift = 0;
    m_period = 0; m_timer = 0; m_step = 0; m_len = 0;
    m_estart = 0; m_decay = 0; m_ediv = 0; m_sdiv = 0; m_sreload = 0;
  endtask

  task automatic model_step();
    int p;
    int v;
    p = m_period;
    v = in_val;
    if (in_ce) begin
      if (m_timer == 0) begin
        m_timer = p;
        m_step = (m_step + 1) % 8;
      end else m_timer--;
    end
    if (in_quarter) begin
      if (m_estart != 0) begin
        m_estart = 0; m_decay = 15; m_ediv = m_vol;
      end else if (m_ediv == 0) begin
        m_ediv = m_vol;
        if (m_decay > 0) m_decay--;
        else if (m_halt != 0) m_decay = 15;
      end else m_ediv--;
    end
    if (in_half && m_halt == 0 && m_len > 0) m_len--;
`ifdef NESAPU_SWEEP_EN
    if (in_half) begin
      if (m_sdiv == 0 && m_sen != 0 && m_shift != 0 && model_mute() == 0)
        m_period = tgt(p, m_shift, m_neg) & 'h7FF;
      if (m_sdiv == 0 || m_sreload != 0) begin
        m_sdiv = m_sp; m_sreload = 0;
      end else m_sdiv--;
    end
`endif
    if (in_wr) begin
      case (in_addr)
        2'd0: begin
          m_duty = v >> 6; m_halt = (v >> 5) & 1; m_const = (v >> 4) & 1; m_vol = v & 15;
        end
        2'd1: begin
`ifdef NESAPU_SWEEP_EN
          m_sen = (v >> 7) & 1; m_sp = (v >> 4) & 7; m_neg = (v >> 3) & 1; m_shift = v & 7;
          m_sreload = 1;
`endif
        end
        2'd2: m_period = (p & 'h700) | v;
        default: begin
          m_period = ((v & 7) << 8) | (p & 'hFF);
          m_step = 0;
          m_estart = 1;
          if (in_enable) m_len = len_tab[v >> 3];
        end
      endcase
    end
    if (!in_enable) m_len = 0;
  endtask

  always @(posedge in_clk or posedge in_rst) begin
    if (in_rst) model_clear();
    else model_step();
  end

  always @(negedge in_clk) begin
    check("level", out_level, expected_level());
    check("active", out_active, (m_len != 0) ? 1 : 0);
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic wr(input int a, input int v);
    in_wr = 1'b1; in_addr = 2'(a); in_val = 8'(v);
    tick();
    in_wr = 1'b0;
  endtask

  task automatic do_reset();
    in_rst = 1'b1; in_ce = 1'b0; in_quarter = 1'b0; in_half = 1'b0; in_enable = 1'b1;
    tick();
    in_rst = 1'b0;
    tick();
  endtask

  int p34[8] = '{0, 15, 15, 15, 15, 0, 0, 0};

  initial begin
    int e;
    int n;
    tick(); tick();
    check("reset_level", out_level, 0);
    check("reset_active", out_active, 0);
    in_rst = 1'b0;
    tick();
    check("post_reset_level", out_level, 0);

    // Duty 2 waveform, period 8.
    do_reset();
    wr(0, 'hBF); wr(2, 'h08); wr(3, 'h08);
    in_ce = 1'b1;
    for (int k = 0; k < 72; k++) begin
      tick();
      check("duty2_wave", out_level, p34[(1 + k / 9) % 8]);
    end
    in_ce = 1'b0;

    // Envelope decay with vol 2.
    do_reset();
    wr(0, 'hC2); wr(2, 'h40); wr(3, 'h08);
    in_quarter = 1'b1;
    for (int q = 1; q <= 50; q++) begin
      tick();
      e = 15 - (q - 1) / 3;
      if (e < 0) e = 0;
      check("env_decay", out_level, e);
    end
    in_quarter = 1'b0;

    // Length 254 expiry, then enable drop.
    do_reset();
    wr(0, 'hC2); wr(3, 'h08);
    in_half = 1'b1;
    for (int h = 1; h <= 254; h++) begin
      tick();
      if (h == 253) check("len_253", out_active, 1);
      if (h == 254) check("len_254", out_active, 0);
    end
    in_half = 1'b0;
    wr(3, 'h08);
    check("len_reload", out_active, 1);
    in_enable = 1'b0;
    tick();
    check("len_disable", out_active, 0);
    in_enable = 1'b1;

`ifdef NESAPU_SWEEP_EN
    do_reset();
    wr(2, 'h00); wr(3, 'h01); wr(1, 'h89);
    in_half = 1'b1; tick(); in_half = 1'b0;
    check("sweep_negate", dut.period, 'h07F);
    do_reset();
    wr(2, 'h00); wr(3, 'h01); wr(1, 'h81);
    in_half = 1'b1; tick(); in_half = 1'b0;
    check("sweep_add", dut.period, 'h180);
    do_reset();
    wr(0, 'hFF); wr(2, 'hF0); wr(3, 'h0F); wr(1, 'h01);
    check("mute_overflow", out_level, 0);
    wr(2, 'h07); wr(3, 'h08);
    check("mute_small", out_level, 0);
    wr(2, 'h00); wr(3, 'h09);
    check("unmuted", out_level, 15);
`else
    do_reset();
    wr(2, 'h00); wr(3, 'h01); wr(1, 'h81);
    in_half = 1'b1; tick(); in_half = 1'b0;
    check("no_sweep", dut.period, 'h100);
    do_reset();
    wr(0, 'hFF); wr(2, 'hF0); wr(3, 'h0F); wr(1, 'h01);
    check("no_mute", out_level, 15);
`endif

    // Asynchronous reset mid-note; a write during reset is dropped.
    do_reset();
    wr(0, 'hBF); wr(2, 'h08); wr(3, 'h08);
    in_ce = 1'b1;
    n = $urandom_range(60, 20);
    repeat (n) tick();
    #2 in_rst = 1'b1;
    #1;
    check("async_rst_level", out_level, 0);
    check("async_rst_active", out_active, 0);
    in_ce = 1'b0;
    tick();
    wr(3, 'h08);
    in_rst = 1'b0;
    tick();
    check("rst_write_ignored", out_active, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      in_ce = 1'($urandom % 2);
      in_wr = ($urandom % 8) == 0;
      in_addr = 2'($urandom % 4);
      if (in_addr == 2'd2) in_val = 8'($urandom % 32);
      else if (in_addr == 2'd3) in_val = 8'(($urandom % 32) << 3);
      else in_val = 8'($urandom);
      in_enable = ($urandom % 64) != 0;
      in_quarter = ($urandom % 16) == 0;
      in_half = ($urandom % 24) == 0;
      in_rst = ($urandom % 700) == 0;
      tick();
    end
    in_rst = 1'b0; in_wr = 1'b0; in_quarter = 1'b0; in_half = 1'b0; in_ce = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
